instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
Encode-side counterpart of the immediate extender. It accepts instruction field bundles (format, opcode, registers, functs, 32-bit immediate) and packs each into a 32-bit RV32I instruction word. It scatters the immediate into the format-specific bit positions, range-checks it, and emits the word with an auto-incrementing instruction-memory address. It is used by the boot/program loader and by self-test benches to build instruction images for imem.

Parameters:
BASE_ADDR, 32'h0000_0000, address assigned to the first emitted word after reset/restart
ADDR_STEP, 4, byte increment of out_addr per emitted word

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
restart  in  1  one-cycle pulse; returns the address counter to BASE_ADDR
in_valid  in  1  input bundle valid
in_ready  out  1  packer can accept a bundle this cycle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_opcode  in  7  opcode[6:0]
in_rd  in  5  rd
in_rs1  in  5  rs1
in_rs2  in  5  rs2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  byte-offset/immediate value, as ext_imm would present it
out_valid  out  1  packed word valid
out_ready  in  1  sink accepts the word
out_instr  out  32  packed instruction
out_addr  out  32  imem byte address for out_instr
out_err  out  1  this word is a substitution caused by a rejected bundle
out_err_code  out  2  0 none, 1 imm out of range, 2 misaligned, 3 illegal fmt

Behaviour:
- Reset (rst=1 at edge): s0_valid=0, s1_valid=0, out_valid=0, out_instr=0, out_err=0, out_err_code=0, addr counter=BASE_ADDR, out_addr=BASE_ADDR. Reset mid-transfer discards both stages with no output.
- Two-stage pipeline:
  - S0 registers the accepted bundle.
  - S1 is the output register, holding packed word, error fields and address.
  - Transfer happens when valid&&ready on either side.
- in_ready = !s0_valid || !s1_valid || out_ready. This gives full throughput of 1 word/cycle with out_ready=1.
- Latency: bundle accepted at edge N -> out_valid=1 after edge N+1.
- Backpressure: out_* hold stable while out_valid&&!out_ready. No bundle is lost or duplicated.
- Packing, bit layout from MSB to LSB:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Checks, evaluated in S0, first match wins:
  - fmt 6/7 -> code 3.
  - B or J with imm[0]=1 -> code 2.
  - I/S with imm[31:11] not all equal -> code 1.
  - B with imm[31:12] not all equal -> code 1.
  - J with imm[31:20] not all equal -> code 1.
  - U with imm[11:0]!=0 -> code 1.
  - R ignores in_imm.
- Rejected bundle: out_instr=32'h0000_0013 (addi x0,x0,0), out_err=1, code as above. The word still consumes an address slot.
- Address counter:
  - Each S1 load takes out_addr = counter, then counter += ADDR_STEP.
  - Wraps modulo 2^32.
- restart:
  - Sets counter=BASE_ADDR at the edge. The word loading S1 in the same cycle gets BASE_ADDR and the counter becomes BASE_ADDR+ADDR_STEP.
  - Does not flush data or alter an already-held S1 word.

Optional Feature:
Macro INSTR_PACKER_SELFCHECK_EN.
- With the macro defined:
  - Adds output port selfcheck_fail (1 bit, reset 0, sticky until rst).
  - S1 re-extracts the immediate from out_instr using the immediate-extender rules per format.
  - Sets selfcheck_fail if the result differs from the captured in_imm on any non-error word.
- Without it: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Format vectors, out_ready=1, back-to-back from reset, BASE_ADDR=0:
  - J op=6F rd=1 imm=FFFFFFFC -> FFDFF0EF @0
  - I op=03 rd=5 rs1=6 f3=0 imm=28 -> 02830283 @4
  - B op=63 rs1=4 rs2=9 f3=4 imm=FFFFFFEC -> FE9246E3 @8
  - S op=23 rs1=5 rs2=1 f3=1 imm=0 -> 00129023 @C
  - U op=17 rd=2 imm=1000 -> 00001117 @10
  - Expected: first out_valid 2 cycles after first accept, one word per cycle, out_err=0.
- Backpressure: same stream, out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 held bundles, out_* stable, order/addresses unchanged, no loss.
- Errors:
  - B imm=3 -> 00000013, err=1, code=2.
  - I imm=800 -> 00000013, code=1.
  - U imm=1001 -> code=1.
  - fmt=7 -> code=3.
  - Each error word still advances the address by 4.
- Restart: pulse restart coincident with an S1 load after address 10 -> that word @0, next @4.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, out_addr=0; next accepted bundle emitted @0.
- (INSTR_PACKER_SELFCHECK_EN) run vectors 1 and 3 -> selfcheck_fail stays 0.

Source files
------------

// File: rtl/instr_packer.sv
// Packs RV32I field bundles into instruction words with sequential imem addresses.
// Optional macro INSTR_PACKER_SELFCHECK_EN adds a sticky immediate round-trip checker.
module instr_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [1:0]  out_err_code
`ifdef INSTR_PACKER_SELFCHECK_EN
    ,
    output logic        selfcheck_fail
`endif
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT   = 2'd3;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    logic            s0_valid;
    logic [2:0]      s0_fmt;
    logic [6:0]      s0_opcode;
    logic [4:0]      s0_rd;
    logic [4:0]      s0_rs1;
    logic [4:0]      s0_rs2;
    logic [2:0]      s0_funct3;
    logic [6:0]      s0_funct7;
    logic [XLEN-1:0] s0_imm;
    logic [XLEN-1:0] addr_cnt;

    logic            s0_load;
    logic            s1_load;
    logic [XLEN-1:0] addr_base;
    logic [XLEN-1:0] pack_word;
    logic [1:0]      pack_code;
    logic            imm_bad;
    logic            align_bad;
    logic            fmt_bad;

    assign in_ready  = !s0_valid || !out_valid || out_ready;
    assign s0_load   = in_valid && in_ready;
    assign s1_load   = s0_valid && (!out_valid || out_ready);
    assign addr_base = restart ? BASE_ADDR : addr_cnt;

    // Scatter the immediate per format and classify the bundle; first failing check wins.
    always_comb begin
        pack_word = NOP_WORD;
        imm_bad   = 1'b0;
        align_bad = 1'b0;
        fmt_bad   = 1'b0;
        case (s0_fmt)
            FMT_R: pack_word = {s0_funct7, s0_rs2, s0_rs1, s0_funct3, s0_rd, s0_opcode};
            FMT_I: begin
                pack_word = {s0_imm[11:0], s0_rs1, s0_funct3, s0_rd, s0_opcode};
                imm_bad   = !((&s0_imm[31:11]) || !(|s0_imm[31:11]));
            end
            FMT_S: begin
                pack_word = {s0_imm[11:5], s0_rs2, s0_rs1, s0_funct3, s0_imm[4:0], s0_opcode};
                imm_bad   = !((&s0_imm[31:11]) || !(|s0_imm[31:11]));
            end
            FMT_B: begin
                pack_word = {s0_imm[12], s0_imm[10:5], s0_rs2, s0_rs1, s0_funct3,
                             s0_imm[4:1], s0_imm[11], s0_opcode};
                imm_bad   = !((&s0_imm[31:12]) || !(|s0_imm[31:12]));
                align_bad = s0_imm[0];
            end
            FMT_U: begin
                pack_word = {s0_imm[31:12], s0_rd, s0_opcode};
                imm_bad   = |s0_imm[11:0];
            end
            FMT_J: begin
                pack_word = {s0_imm[20], s0_imm[10:1], s0_imm[11], s0_imm[19:12], s0_rd, s0_opcode};
                imm_bad   = !((&s0_imm[31:20]) || !(|s0_imm[31:20]));
                align_bad = s0_imm[0];
            end
            default: fmt_bad = 1'b1;
        endcase
        if (fmt_bad)        pack_code = ERR_FMT;
        else if (align_bad) pack_code = ERR_ALIGN;
        else if (imm_bad)   pack_code = ERR_RANGE;
        else                pack_code = ERR_NONE;
        if (pack_code != ERR_NONE) pack_word = NOP_WORD;
    end

    // Bundle payload capture; qualified by s0_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (s0_load) begin
            s0_fmt    <= in_fmt;
            s0_opcode <= in_opcode;
            s0_rd     <= in_rd;
            s0_rs1    <= in_rs1;
            s0_rs2    <= in_rs2;
            s0_funct3 <= in_funct3;
            s0_funct7 <= in_funct7;
            s0_imm    <= in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_err      <= 1'b0;
            out_err_code <= ERR_NONE;
            out_addr     <= BASE_ADDR;
            addr_cnt     <= BASE_ADDR;
        end else begin
            if (s0_load)      s0_valid <= 1'b1;
            else if (s1_load) s0_valid <= 1'b0;

            if (s1_load) begin
                out_valid    <= 1'b1;
                out_instr    <= pack_word;
                out_err      <= (pack_code != ERR_NONE);
                out_err_code <= pack_code;
                out_addr     <= addr_base;
                addr_cnt     <= addr_base + ADDR_STEP;
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (restart)   addr_cnt  <= BASE_ADDR;
            end
        end
    end

`ifdef INSTR_PACKER_SELFCHECK_EN
    logic [2:0]      s1_fmt;
    logic [XLEN-1:0] s1_imm;
    logic [XLEN-1:0] ext_imm;

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_fmt <= s0_fmt;
            s1_imm <= s0_imm;
        end
    end

    // Immediate-extender view of the held word.
    always_comb begin
        ext_imm = s1_imm;
        case (s1_fmt)
            FMT_I: ext_imm = {{20{out_instr[31]}}, out_instr[31:20]};
            FMT_S: ext_imm = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
            FMT_B: ext_imm = {{19{out_instr[31]}}, out_instr[31], out_instr[7],
                              out_instr[30:25], out_instr[11:8], 1'b0};
            FMT_U: ext_imm = {out_instr[31:12], 12'h000};
            FMT_J: ext_imm = {{11{out_instr[31]}}, out_instr[31], out_instr[19:12],
                              out_instr[20], out_instr[30:21], 1'b0};
            default: ext_imm = s1_imm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selfcheck_fail <= 1'b0;
        end else if (out_valid && !out_err && (ext_imm != s1_imm)) begin
            selfcheck_fail <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_packer.sv
// Randomized self-checking bench for instr_packer against a queue-based reference model.
module tb_instr_packer;
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bnd_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [1:0]  out_err_code;
`ifdef INSTR_PACKER_SELFCHECK_EN
    logic        selfcheck_fail;
`endif

    instr_packer dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .out_err_code(out_err_code)
`ifdef INSTR_PACKER_SELFCHECK_EN
        , .selfcheck_fail(selfcheck_fail)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bnd_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [31:0] imm);
        bnd_t b;
        b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.f3 = f3; b.f7 = 7'h00; b.imm = imm;
        return b;
    endfunction

    // Reference: range as signed interval, alignment, then field placement.
    function automatic exp_t model(input bnd_t b);
        exp_t e;
        longint s;
        logic [31:0] m;
        s = longint'($signed(b.imm));
        m = b.imm;
        e.instr = 32'h0000_0013;
        e.err = 1'b0;
        e.code = 2'd0;
        if (b.fmt > 3'd5) e.code = 2'd3;
        else if ((b.fmt == 3'd3 || b.fmt == 3'd5) && m[0]) e.code = 2'd2;
        else if (((b.fmt == 3'd1 || b.fmt == 3'd2) && (s < -2048 || s > 2047)) ||
                 (b.fmt == 3'd3 && (s < -4096 || s > 4095)) ||
                 (b.fmt == 3'd5 && (s < -1048576 || s > 1048575)) ||
                 (b.fmt == 3'd4 && (m % 4096) != 0)) e.code = 2'd1;
        if (e.code != 2'd0) begin
            e.err = 1'b1;
        end else begin
            case (b.fmt)
                3'd0: e.instr = {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
                3'd1: e.instr = {m[11:0], b.rs1, b.f3, b.rd, b.op};
                3'd2: e.instr = {m[11:5], b.rs2, b.rs1, b.f3, m[4:0], b.op};
                3'd3: e.instr = {m[12], m[10:5], b.rs2, b.rs1, b.f3, m[4:1], m[11], b.op};
                3'd4: e.instr = {m[31:12], b.rd, b.op};
                default: e.instr = {m[20], m[10:1], m[11], m[19:12], b.rd, b.op};
            endcase
        end
        return e;
    endfunction

    function automatic bnd_t rnd_bnd();
        bnd_t b;
        logic [31:0] r;
        r = $urandom;
        b.fmt = 3'($urandom_range(0, 7));
        b.op = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom); b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        case ($urandom % 4)
            0: b.imm = r;
            1: b.imm = {{20{r[11]}}, r[11:0]};
            2: b.imm = {{11{r[20]}}, r[20:1], ($urandom % 8 == 0)};
            default: b.imm = {r[31:12], 12'h000};
        endcase
        return b;
    endfunction

    // Model state advanced by the compare process.
    exp_t        q[$];
    int          inflight = 0;
    logic [31:0] cnt = 32'h0;
    logic        p_rst = 1'b1, p_restart = 1'b0, p_acc = 1'b0, p_hs = 1'b0;
    logic        p_valid = 1'b0, p_ready = 1'b0;
    exp_t        held;
    logic [31:0] held_addr = '0;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ea;
        logic new_word;
        if (p_rst) begin
            q.delete();
            inflight = 0;
            cnt = 32'h0;
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_addr", out_addr, 32'h0);
            chk("rst_instr", out_instr, 32'h0);
            chk("rst_err", {29'h0, out_err, out_err_code}, 32'h0);
        end else begin
            inflight = inflight + int'(p_acc) - int'(p_hs);
            new_word = out_valid && (!p_valid || p_ready);
            if (new_word) begin
                if (q.size() == 0) begin
                    chk("spurious_word", 32'(out_valid), 32'h0);
                end else begin
                    e = q.pop_front();
                    ea = p_restart ? 32'h0 : cnt;
                    cnt = ea + 32'd4;
                    chk("instr", out_instr, e.instr);
                    chk("err", 32'(out_err), 32'(e.err));
                    chk("code", 32'(out_err_code), 32'(e.code));
                    chk("addr", out_addr, ea);
                end
            end else begin
                if (p_restart) cnt = 32'h0;
                if (out_valid) begin
                    chk("hold_instr", out_instr, held.instr);
                    chk("hold_addr", out_addr, held_addr);
                    chk("hold_err", {29'h0, out_err, out_err_code}, {29'h0, held.err, held.code});
                end
            end
        end
        chk("in_ready", 32'(in_ready), 32'((inflight < 2) || out_ready));
        held.instr = out_instr; held.err = out_err; held.code = out_err_code;
        held_addr = out_addr;
        p_acc = in_valid && in_ready && !rst;
        if (p_acc) q.push_back(model({in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                      in_funct3, in_funct7, in_imm}));
        p_hs = out_valid && out_ready;
        p_valid = out_valid;
        p_ready = out_ready;
        p_restart = restart;
        p_rst = rst;
    end

    bnd_t pending[$];
    bnd_t vecs[5];
    bnd_t errv[4];

    // Cycle driver. Modes: 0 latency-literal, 1 backpressure, 2 random, 3 restart, 4 reset, 5 plain.
    task automatic run(input int ncyc, input int mode);
        bnd_t b;
        logic acc;
        for (int c = 0; c < ncyc; c++) begin
            b = (pending.size() > 0) ? pending[0] : rnd_bnd();
            in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1;
            in_rs2 = b.rs2; in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
            in_valid  = (pending.size() > 0) && (mode != 2 || ($urandom % 4 != 0));
            out_ready = (mode == 1) ? !(c >= 2 && c <= 6) :
                        (mode == 2) ? ($urandom % 3 != 0) :
                        (mode == 4) ? 1'b0 : 1'b1;
            restart   = (mode == 3 && c == 3) || (mode == 2 && $urandom % 30 == 0);
            rst       = (mode == 4 && c == 4);
            @(negedge clk);
            if (mode == 0 && c == 1) chk("lat_not_yet", 32'(out_valid), 32'h0);
            if (mode == 0 && c == 2) begin
                chk("lat_valid", 32'(out_valid), 32'h1);
                chk("lit_j_word", out_instr, 32'hFFDFF0EF);
                chk("lit_j_addr", out_addr, 32'h0);
            end
            if (mode == 0 && c == 6) begin
                chk("lit_u_word", out_instr, 32'h00001117);
                chk("lit_u_addr", out_addr, 32'h10);
            end
            if (mode == 1 && c == 3) chk("bp_ready_low", 32'(in_ready), 32'h0);
            if (mode == 3 && c == 4) chk("restart_addr0", {out_addr[31:1], out_valid}, 32'h1);
            if (mode == 3 && c == 5) chk("restart_addr4", out_addr, 32'h4);
            if (mode == 4 && c == 5) chk("midrst_flush", {out_addr[31:1], out_valid}, 32'h0);
            acc = in_valid && in_ready && !rst;
            @(posedge clk);
            if (acc) void'(pending.pop_front());
            #1;
        end
        in_valid = 1'b0;
        restart = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        exp_t e;
        int guard;
        vecs[0] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        vecs[1] = mk(3'd1, 7'h03, 5'd5, 5'd6, 5'd0, 3'd0, 32'h0000_0028);
        vecs[2] = mk(3'd3, 7'h63, 5'd0, 5'd4, 5'd9, 3'd4, 32'hFFFF_FFEC);
        vecs[3] = mk(3'd2, 7'h23, 5'd0, 5'd5, 5'd1, 3'd1, 32'h0000_0000);
        vecs[4] = mk(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 32'h0000_1000);
        errv[0] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0003);
        errv[1] = mk(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'h0000_0800);
        errv[2] = mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_1001);
        errv[3] = mk(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0000_0000);

        // Pin the reference model to hand-computed words.
        chk("model_j", model(vecs[0]).instr, 32'hFFDFF0EF);
        chk("model_i", model(vecs[1]).instr, 32'h02830283);
        chk("model_b", model(vecs[2]).instr, 32'hFE9246E3);
        chk("model_s", model(vecs[3]).instr, 32'h00129023);
        chk("model_u", model(vecs[4]).instr, 32'h00001117);
        e = model(errv[0]); chk("model_b_align", {e.instr[29:0], e.code}, {30'h13, 2'd2});
        e = model(errv[1]); chk("model_i_range", {e.instr[29:0], e.code}, {30'h13, 2'd1});
        e = model(errv[2]); chk("model_u_range", {31'h0, e.err, e.code}, 32'h5);
        e = model(errv[3]); chk("model_fmt", {31'h0, e.err, e.code}, 32'h7);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_ready", 32'(in_ready), 32'h1);
        chk("init_addr", out_addr, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) pending.push_back(vecs[i]);
        run(8, 0);
        for (int i = 0; i < 5; i++) pending.push_back(vecs[i]);
        run(14, 1);
        for (int i = 0; i < 4; i++) pending.push_back(errv[i]);
        run(8, 5);
        for (int i = 0; i < 6; i++) pending.push_back(vecs[i % 5]);
        run(10, 3);
        for (int i = 0; i < 4; i++) pending.push_back(vecs[i]);
        run(6, 4);
        run(6, 5);

        for (int i = 0; i < 400; i++) pending.push_back(rnd_bnd());
        guard = 0;
        while (pending.size() > 0 && guard < 200) begin
            run(20, 2);
            guard++;
        end
        chk("random_drain", 32'(pending.size()), 32'h0);
        run(6, 5);
        chk("queue_empty", 32'(q.size()), 32'h0);
        chk("inflight_zero", 32'(inflight), 32'h0);
`ifdef INSTR_PACKER_SELFCHECK_EN
        chk("selfcheck_fail", 32'(selfcheck_fail), 32'h0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
